// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// op encodings, register aliases and small decode helpers.
package mul_div_unit_pkg;

    // Datapath width; tracks the register-file data width.
    localparam int MD_WIDTH   = 16;
    // Iteration counter width; 2**MD_CNT_W must exceed MD_WIDTH.
    localparam int MD_CNT_W   = 5;
    // Cycles from acceptance to the next possible acceptance (control stall).
    localparam int MD_LATENCY = MD_WIDTH + 2;

    // Operation encodings as presented on op.
    typedef enum logic [1:0] {
        MD_MUL_LO   = 2'b00,
        MD_MUL_HI   = 2'b01,
        MD_DIV_QUOT = 2'b10,
        MD_DIV_REM  = 2'b11
    } md_op_e;

    // Register-file aliases used as destination indices.
    localparam logic [3:0] R0     = 4'd0;
    localparam logic [3:0] R_ZERO = 4'd0;

    // Divide ops share op[1] = 1.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // High-half ops (mul_hi / div_rem) share op[0] = 1.
    function automatic logic md_is_hi(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between issue control, the register-file read
// ports and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 16
);
    // Request side (from control / register-file read ports)
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [3:0]       dest_reg;

    // Response side (to control stall and register-file write port)
    logic             busy;
    logic             done;
    logic             reg_write;
    logic [3:0]       write_reg;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    // Requester: drives the operation, watches busy/completion.
    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, done, reg_write, write_reg, result, div_by_zero
    );

    // The unit itself.
    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, done, reg_write, write_reg, result, div_by_zero
    );

endinterface

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration, purely combinational.
// The dividend is shifted in MSB-first from the quotient register while the
// quotient bits shift in from the bottom, so after WIDTH steps quot_o holds
// the quotient and rem_o the remainder. A zero divisor always "fits",
// giving an all-ones quotient and remainder == dividend.
module mul_div_unit_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             take;

    // Shift next dividend bit into the partial remainder, subtract if it fits.
    // The difference is only kept when it is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        take    = (shifted >= {1'b0, divisor_i});
        diff    = shifted[WIDTH-1:0] - divisor_i;
        rem_o   = take ? diff : shifted[WIDTH-1:0];
        quot_o  = {quot_i[WIDTH-2:0], take};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit.
// IDLE -> CALC (WIDTH iterations) -> DONE (one cycle) -> IDLE.
// Operands are captured on acceptance only; result, write_reg and
// div_by_zero are loaded on the final iteration and held afterwards.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Control state
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Captured request
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         dest_q, dest_d;

    // Accumulators: product {hi, lo}; divider remainder / quotient
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;

    // Held outputs
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         write_reg_q, write_reg_d;
    logic               dbz_q, dbz_d;

    // One-iteration results
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;
    logic [WIDTH-1:0]   sel_result;

    // Shift-add multiply step: add multiplicand into the high half when the
    // current multiplier bit (prod_q[0]) is set, then shift right one place.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    end

    mul_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (b_q),
        .rem_o     (rem_step),
        .quot_o    (quot_step)
    );

    // Pick the final result from the values the last iteration produces.
    always_comb begin
        case ({md_is_div(op_q), md_is_hi(op_q)})
            2'b00:   sel_result = prod_step[WIDTH-1:0];
            2'b01:   sel_result = prod_step[2*WIDTH-1:WIDTH];
            2'b10:   sel_result = quot_step;
            default: sel_result = rem_step;
        endcase
    end

    // Next-state: accept in IDLE, iterate in CALC, publish on the last step.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        dest_d      = dest_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        result_d    = result_q;
        write_reg_d = write_reg_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = bus.op;
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    dest_d  = bus.dest_reg;
                    // Multiplier sits in the low half and is consumed LSB first.
                    prod_d  = {{WIDTH{1'b0}}, bus.operand_b};
                    // Dividend is consumed MSB first out of the quotient register.
                    rem_d   = '0;
                    quot_d  = bus.operand_a;
                    dbz_d   = 1'b0;
                end
            end

            S_CALC: begin
                prod_d = prod_step;
                rem_d  = rem_step;
                quot_d = quot_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = S_DONE;
                    result_d    = sel_result;
                    write_reg_d = dest_q;
                    dbz_d       = md_is_div(op_q) && (b_q == '0);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dest_q      <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            result_q    <= '0;
            write_reg_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dest_q      <= dest_d;
            prod_q      <= prod_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            result_q    <= result_d;
            write_reg_q <= write_reg_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.reg_write   = (state_q == S_DONE);
    assign bus.write_reg   = write_reg_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule
